// File: rtl/sync_debouncer_if.sv
// Signal bundle between a debouncer and its consumer.
// The debouncer sits on the slave side and publishes the qualified level and event outputs.
interface sync_debouncer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 x_sync;
    logic                 clear_count;
    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] event_count;
    logic                 event_overflow;

    modport master (
        output enable,
        output x_sync,
        output clear_count,
        input  level,
        input  rise,
        input  fall,
        input  event_count,
        input  event_overflow
    );

    modport slave (
        input  enable,
        input  x_sync,
        input  clear_count,
        output level,
        output rise,
        output fall,
        output event_count,
        output event_overflow
    );
endinterface

// File: rtl/sync_debouncer.sv
// Glitch filter for an already-synchronized bit: the level follows x_sync only after
// FILTER_CYCLES consecutive equal samples, with registered edge pulses and a saturating rise counter.
module sync_debouncer #(
    parameter int   FILTER_CYCLES = 16,
    parameter int   CNT_WIDTH     = 16,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input logic             clock,
    input logic             reset_n,
    sync_debouncer_if.slave bus
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] LAST = FW'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    state_t               state, state_nx;
    logic [FW-1:0]        filt, filt_nx;
    logic                 level_q, level_nx;
    logic                 rise_q, rise_nx;
    logic                 fall_q, fall_nx;
    logic [CNT_WIDTH-1:0] count_q, count_nx;
    logic                 ovf_q, ovf_nx;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= RESET_STATE;
            filt    <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            filt    <= filt_nx;
            level_q <= level_nx;
            rise_q  <= rise_nx;
            fall_q  <= fall_nx;
            count_q <= count_nx;
            ovf_q   <= ovf_nx;
        end
    end

    // filt counts samples already seen at the new value; the sample that makes it FILTER_CYCLES commits.
    always_comb begin
        state_nx = state;
        filt_nx  = filt;
        level_nx = level_q;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (bus.enable && bus.x_sync) begin
                    if (FILTER_CYCLES == 1) begin
                        state_nx = STABLE_HI;
                        level_nx = 1'b1;
                        rise_nx  = 1'b1;
                        filt_nx  = '0;
                    end else begin
                        state_nx = PEND_HI;
                        filt_nx  = FW'(1);
                    end
                end
            end
            PEND_HI: begin
                if (!bus.enable || !bus.x_sync) begin
                    state_nx = STABLE_LO;
                    filt_nx  = '0;
                end else if (filt == LAST) begin
                    state_nx = STABLE_HI;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                    filt_nx  = '0;
                end else begin
                    filt_nx = filt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (bus.enable && !bus.x_sync) begin
                    if (FILTER_CYCLES == 1) begin
                        state_nx = STABLE_LO;
                        level_nx = 1'b0;
                        fall_nx  = 1'b1;
                        filt_nx  = '0;
                    end else begin
                        state_nx = PEND_LO;
                        filt_nx  = FW'(1);
                    end
                end
            end
            PEND_LO: begin
                if (!bus.enable || bus.x_sync) begin
                    state_nx = STABLE_HI;
                    filt_nx  = '0;
                end else if (filt == LAST) begin
                    state_nx = STABLE_LO;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                    filt_nx  = '0;
                end else begin
                    filt_nx = filt + 1'b1;
                end
            end
            default: begin
                state_nx = RESET_STATE;
                filt_nx  = '0;
                level_nx = RESET_LEVEL;
            end
        endcase
    end

    // Clear is applied before a same-edge rise, so clear+rise lands on a count of one.
    always_comb begin
        count_nx = count_q;
        ovf_nx   = ovf_q;
        if (bus.clear_count) begin
            count_nx = '0;
            ovf_nx   = 1'b0;
        end
        if (rise_nx) begin
            if (count_nx == '1) begin
                ovf_nx = 1'b1;
            end else begin
                count_nx = count_nx + 1'b1;
            end
        end
    end

    assign bus.level          = level_q;
    assign bus.rise           = rise_q;
    assign bus.fall           = fall_q;
    assign bus.event_count    = count_q;
    assign bus.event_overflow = ovf_q;
endmodule
